// File: rtl/sfp_pkg.sv
// Shared definitions for the 26-bit sfp format: field layout, exponent bias and
// field extraction helpers used by the sfp datapath units.
package sfp_pkg;

   localparam int unsigned SFP_W         = 26;
   localparam int unsigned SFP_EXP_BIAS  = 127;
   localparam int unsigned SFP_MANT_FRAC = 16;
   localparam int unsigned SFP_SIGN      = 25;
   localparam int unsigned SFP_EXP_HI    = 24;
   localparam int unsigned SFP_EXP_LO    = 17;
   localparam int unsigned SFP_FRAC_HI   = 16;
   localparam int unsigned SFP_MANT_W    = 18;
   localparam int unsigned SFP_EXP_W     = 8;

   // Shift class decided in stage 2 and consumed by the shift/saturate core
   typedef enum logic [1:0] {
      CLS_LEFT  = 2'd0,
      CLS_RIGHT = 2'd1,
      CLS_ZERO  = 2'd2,
      CLS_SAT   = 2'd3
   } shift_cls_e;

   // Signed 18-bit mantissa {sign, frac}, 16 fractional bits
   function automatic logic signed [SFP_MANT_W-1:0] sfp_mant(input logic [SFP_W-1:0] d);
      return {d[SFP_SIGN], d[SFP_FRAC_HI:0]};
   endfunction

   function automatic logic [SFP_EXP_W-1:0] sfp_exp(input logic [SFP_W-1:0] d);
      return d[SFP_EXP_HI:SFP_EXP_LO];
   endfunction

endpackage

// File: rtl/sfp_shift_sat.sv
// Final-stage combinational core: bidirectional shift of the sign-extended
// mantissa with saturation to the signed OUT_W range.
module sfp_shift_sat
   import sfp_pkg::*;
#(
   parameter int unsigned OUT_W = 32,
   parameter int unsigned SH_W  = 6
) (
   input  shift_cls_e                          cls,
   input  logic signed [OUT_W+SFP_MANT_W-1:0]  ext,
   input  logic [SH_W-1:0]                     sh,
   output logic [OUT_W-1:0]                    res_c,
   output logic                                ovf_c
);

   localparam int unsigned EXT_W = OUT_W + SFP_MANT_W;

   logic signed [EXT_W-1:0] wide_l;
   logic [EXT_W-OUT_W:0]    hi;
   logic                    neg;
   logic [OUT_W-1:0]        sat_v;

   // Left result fits iff every bit from OUT_W-1 upward is a sign copy
   always_comb begin
      wide_l = ext <<< sh;
      hi     = wide_l[EXT_W-1:OUT_W-1];
      neg    = ext[EXT_W-1];
      sat_v  = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      res_c  = wide_l[OUT_W-1:0];
      ovf_c  = 1'b0;
      case (cls)
         CLS_LEFT: begin
            if (!((&hi) || (~|hi))) begin
               res_c = sat_v;
               ovf_c = 1'b1;
            end
         end
         CLS_RIGHT: res_c = OUT_W'(ext >>> sh);
         CLS_ZERO:  res_c = {OUT_W{neg}};
         CLS_SAT: begin
            res_c = sat_v;
            ovf_c = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sfp_to_fix.sv
// Three-stage sfp to signed fixed-point converter; one result per cycle,
// valid-tagged, saturating with an overflow flag.
module sfp_to_fix
   import sfp_pkg::*;
#(
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned FRAC_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic [SFP_W-1:0]  i_d,
   output logic              o_vld,
   output logic [OUT_W-1:0]  o_do,
   output logic              o_ovf
);

   localparam int unsigned EXT_W = OUT_W + SFP_MANT_W;
   localparam int unsigned SH_W  = $clog2(OUT_W + 1);
   localparam int unsigned S_W   = 10;
   localparam int          S_OFS = int'(FRAC_W) - int'(SFP_EXP_BIAS) - int'(SFP_MANT_FRAC);

   logic                         p1_vld_q, p1_vld_d;
   logic signed [SFP_MANT_W-1:0] m_q, m_d;
   logic signed [S_W-1:0]        s_q, s_d;
   logic                         p2_vld_q, p2_vld_d;
   shift_cls_e                   cls_q, cls_d;
   logic signed [EXT_W-1:0]      ext_q, ext_d;
   logic [SH_W-1:0]              sh_q, sh_d;
   logic                         vld_q, vld_d;
   logic [OUT_W-1:0]             do_q, do_d;
   logic                         ovf_q, ovf_d;

   logic [S_W-1:0]               s_mag;
   logic [OUT_W-1:0]             res_c;
   logic                         ovf_c;

   sfp_shift_sat #(
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
   ) u_shift_sat (
      .cls   (cls_q),
      .ext   (ext_q),
      .sh    (sh_q),
      .res_c (res_c),
      .ovf_c (ovf_c)
   );

   always_comb begin
      p1_vld_d = i_req;
      m_d      = m_q;
      s_d      = s_q;
      p2_vld_d = p1_vld_q;
      cls_d    = cls_q;
      ext_d    = ext_q;
      sh_d     = sh_q;
      vld_d    = p2_vld_q;
      do_d     = do_q;
      ovf_d    = ovf_q;
      s_mag    = s_q[S_W-1] ? S_W'(-s_q) : S_W'(s_q);

      // P1: capture mantissa, fold bias and output scaling into one shift
      if (i_req) begin
         m_d = sfp_mant(i_d);
         s_d = $signed({2'b00, sfp_exp(i_d)}) + S_W'(S_OFS);
      end

      // P2: classify; left shifts clamp at OUT_W where any nonzero M overflows
      if (p1_vld_q) begin
         ext_d = {{OUT_W{m_q[SFP_MANT_W-1]}}, m_q};
         if (!s_q[S_W-1]) begin
            if (s_mag >= S_W'(OUT_W)) begin
               cls_d = (m_q == '0) ? CLS_LEFT : CLS_SAT;
               sh_d  = SH_W'(OUT_W);
            end else begin
               cls_d = CLS_LEFT;
               sh_d  = SH_W'(s_mag);
            end
         end else if (s_mag >= S_W'(SFP_MANT_W)) begin
            cls_d = CLS_ZERO;
            sh_d  = '0;
         end else begin
            cls_d = CLS_RIGHT;
            sh_d  = SH_W'(s_mag);
         end
      end

      // P3: results only update on valid so outputs hold across bubbles
      if (p2_vld_q) begin
         do_d  = res_c;
         ovf_d = ovf_c;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         p1_vld_q <= 1'b0;
         m_q      <= '0;
         s_q      <= '0;
         p2_vld_q <= 1'b0;
         cls_q    <= CLS_LEFT;
         ext_q    <= '0;
         sh_q     <= '0;
         vld_q    <= 1'b0;
         do_q     <= '0;
         ovf_q    <= 1'b0;
      end else begin
         p1_vld_q <= p1_vld_d;
         m_q      <= m_d;
         s_q      <= s_d;
         p2_vld_q <= p2_vld_d;
         cls_q    <= cls_d;
         ext_q    <= ext_d;
         sh_q     <= sh_d;
         vld_q    <= vld_d;
         do_q     <= do_d;
         ovf_q    <= ovf_d;
      end
   end

   assign o_vld = vld_q;
   assign o_do  = do_q;
   assign o_ovf = ovf_q;

endmodule

// File: tb/tb_sfp_to_fix.sv
// Directed and randomized bench for sfp_to_fix (OUT_W=32, FRAC_W=16) against
// an arithmetic reference model of the sfp value.
module tb_sfp_to_fix;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_req = 1'b0;
   logic [25:0] i_d   = '0;
   logic        o_vld;
   logic [31:0] o_do;
   logic        o_ovf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        vld;
      logic [31:0] d;
      logic        ovf;
   } exp_t;

   exp_t pipe[$];

   sfp_to_fix #(
      .OUT_W  (32),
      .FRAC_W (16)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_req (i_req),
      .i_d   (i_d),
      .o_vld (o_vld),
      .o_do  (o_do),
      .o_ovf (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   // value = M * 2^(E-127-16), scaled by 2^16 fractional bits, floored, saturated
   function automatic void model(input logic [25:0] d, output logic [31:0] r, output logic ovf);
      longint m, v, p;
      int     s;
      m   = longint'(d[16:0]) - (d[25] ? 64'sd131072 : 64'sd0);
      s   = int'(d[24:17]) - 127;
      ovf = 1'b0;
      if (m == 0) begin
         v = 0;
      end else if (s >= 0) begin
         if (s >= 32) v = (m > 0) ? 64'sd4294967296 : -64'sd4294967296;
         else         v = m * (longint'(1) << s);
         if (v > 64'sd2147483647)       begin v = 64'sd2147483647;  ovf = 1'b1; end
         else if (v < -64'sd2147483648) begin v = -64'sd2147483648; ovf = 1'b1; end
      end else if (-s >= 18) begin
         v = (m < 0) ? -1 : 0;
      end else begin
         p = longint'(1) << (-s);
         v = m / p;
         if ((m % p != 0) && (m < 0)) v = v - 1;
      end
      r = v[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock with the given input; compares the output owed from 2 edges ago
   task automatic cyc(input logic req, input logic [25:0] d);
      exp_t e;
      i_req = req;
      i_d   = d;
      @(posedge i_clk);
      #1;
      e.vld = req;
      model(d, e.d, e.ovf);
      pipe.push_back(e);
      if (pipe.size() >= 3) begin
         e = pipe.pop_front();
         check("vld", 64'(o_vld), 64'(e.vld));
         if (e.vld) begin
            check("do", 64'(o_do), 64'(e.d));
            check("ovf", 64'(o_ovf), 64'(e.ovf));
         end
      end else begin
         check("vld_fill", 64'(o_vld), 64'd0);
      end
   endtask

   task automatic directed(input string tag, input logic [25:0] d,
                           input logic [31:0] exp_do, input logic exp_ovf);
      cyc(1'b1, d);
      cyc(1'b0, 26'h0);
      cyc(1'b0, 26'h0);
      check({tag, "_vld"}, 64'(o_vld), 64'd1);
      check({tag, "_do"},  64'(o_do),  64'(exp_do));
      check({tag, "_ovf"}, 64'(o_ovf), 64'(exp_ovf));
   endtask

   initial begin
      logic [25:0] d;
      logic [7:0]  e;
      logic [17:0] m;
      logic        req;

      #12;
      check("rst_vld", 64'(o_vld), 64'd0);
      check("rst_do",  64'(o_do),  64'd0);
      check("rst_ovf", 64'(o_ovf), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b1;

      directed("pos1",   26'h00FF0000, 32'h00010000, 1'b0);
      directed("neg1",   26'h02FF0000, 32'hFFFF0000, 1'b0);
      directed("rfloor", 26'h00D70000, 32'h00000000, 1'b0);
      directed("rneg",   26'h02D70000, 32'hFFFFFFFF, 1'b0);
      directed("satp",   26'h01270000, 32'h7FFFFFFF, 1'b1);
      directed("satn",   26'h03270000, 32'h80000000, 1'b1);
      directed("zero_e255", 26'h01FE0000, 32'h00000000, 1'b0);
      directed("mmin_e127", 26'h02FE0000, 32'hFFFE0000, 1'b0);

      // streaming with a bubble
      cyc(1'b1, 26'h01000000);
      cyc(1'b1, 26'h02F91234);
      cyc(1'b0, 26'h00FF0000);
      cyc(1'b1, 26'h0105ABCD);
      repeat (3) cyc(1'b0, 26'h0);

      for (int i = 0; i < 6000; i++) begin
         req = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2, 3:    e = 8'($urandom_range(87, 167));
            default: e = 8'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       m = 18'h00000;
            1:       m = 18'h20000;
            default: m = 18'($urandom);
         endcase
         d = {m[17], e, m[16:0]};
         cyc(req, d);
      end
      repeat (3) cyc(1'b0, 26'h0);

      // reset with two items in flight behind a saturated result
      cyc(1'b1, 26'h01270000);
      cyc(1'b0, 26'h0);
      cyc(1'b1, 26'h00FF0000);
      cyc(1'b1, 26'h02FF0000);
      #2;
      i_rst = 1'b0;
      #1;
      check("arst_vld", 64'(o_vld), 64'd0);
      check("arst_do",  64'(o_do),  64'd0);
      check("arst_ovf", 64'(o_ovf), 64'd0);
      pipe.delete();
      i_req = 1'b1;
      i_d   = 26'h00FF0000;
      repeat (2) begin
         @(posedge i_clk);
         #1;
         check("inrst_vld", 64'(o_vld), 64'd0);
      end
      @(negedge i_clk);
      i_rst = 1'b1;
      i_req = 1'b0;
      repeat (3) cyc(1'b0, 26'h0);
      directed("post_rst", 26'h00FF0000, 32'h00010000, 1'b0);
      repeat (3) cyc(1'b0, 26'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
